// File: rtl/wb_ram_slave.sv
// Wishbone B4 classic single-port RAM responder with a base-relative address window,
// byte-lane writes, programmable wait states and error termination.
module wb_ram_slave #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        wb_cyc_in,
    input  logic        wb_stb_in,
    input  logic        wb_we_in,
    input  logic [31:0] wb_adr_in,
    input  logic [31:0] wb_dat_in,
    input  logic [3:0]  wb_sel_in,
    output logic [31:0] wb_dat_out,
    output logic        wb_ack_out,
    output logic        wb_err_out
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] WINDOW    = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0]  WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  count;
    logic [31:0] adr_q;
    logic [31:0] dat_q;
    logic [3:0]  sel_q;
    logic        we_q;

    logic [31:0] req_adr;
    logic [31:0] req_dat;
    logic [3:0]  req_sel;
    logic        req_we;
    logic [31:0] offset;
    logic [AW-1:0] index;
    logic        hit;
    logic        accept;
    logic        respond;

    logic [31:0] mem [DEPTH_WORDS];

    // With no wait states the response is built on the accepting edge, so the
    // request is taken straight from the bus instead of from the latched copy.
    always_comb begin
        accept = (state == IDLE) && wb_cyc_in && wb_stb_in;
        if (state == IDLE) begin
            req_adr = wb_adr_in;
            req_dat = wb_dat_in;
            req_sel = wb_sel_in;
            req_we  = wb_we_in;
        end else begin
            req_adr = adr_q;
            req_dat = dat_q;
            req_sel = sel_q;
            req_we  = we_q;
        end
        offset  = req_adr - ADDR_BASE;
        hit     = ({1'b0, offset} < WINDOW) && (req_adr[1:0] == 2'b00);
        index   = offset[AW+1:2];
        respond = (accept && (WAIT_STATES == 0))
                || ((state == WAIT) && wb_cyc_in && (count == 4'd0));
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (WAIT_STATES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (!wb_cyc_in) begin
                    state_next = IDLE;
                end else if (count == 4'd0) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            count      <= 4'd0;
            adr_q      <= 32'h0;
            dat_q      <= 32'h0;
            sel_q      <= 4'h0;
            we_q       <= 1'b0;
            wb_ack_out <= 1'b0;
            wb_err_out <= 1'b0;
            wb_dat_out <= 32'h0;
        end else begin
            wb_ack_out <= 1'b0;
            wb_err_out <= 1'b0;
            wb_dat_out <= 32'h0;
            if (accept) begin
                adr_q <= wb_adr_in;
                dat_q <= wb_dat_in;
                sel_q <= wb_sel_in;
                we_q  <= wb_we_in;
                count <= WAIT_INIT;
            end else if ((state == WAIT) && (count != 4'd0)) begin
                count <= count - 4'd1;
            end
            if (respond) begin
                if (hit) begin
                    wb_ack_out <= 1'b1;
                    if (!req_we) begin
                        wb_dat_out <= mem[index];
                    end
                end else begin
                    wb_err_out <= 1'b1;
                end
            end
        end
    end

    // RAM is never reset; the reset_in term keeps a clock edge during reset from writing.
    always_ff @(posedge clk_in) begin
        if (respond && hit && req_we && reset_in) begin
            for (int b = 0; b < 4; b++) begin
                if (req_sel[b]) begin
                    mem[index][8*b +: 8] <= req_dat[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_ram_slave.sv
// Directed bench for wb_ram_slave: three instances with 0, 3 and 2 wait states share
// one clock and reset; each scenario task drives its own instance and checks inline.
module tb_wb_ram_slave;

    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc  [3];
    logic        stb  [3];
    logic        we   [3];
    logic [31:0] adr  [3];
    logic [31:0] wdat [3];
    logic [3:0]  sel  [3];
    logic [31:0] rdat [3];
    logic        ack  [3];
    logic        err  [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        wb_ram_slave #(
            .DEPTH_WORDS(DEPTH),
            .ADDR_BASE  (BASE),
            .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 3 : 2))
        ) dut (
            .clk_in    (clk),
            .reset_in  (rst_n),
            .wb_cyc_in (cyc[g]),
            .wb_stb_in (stb[g]),
            .wb_we_in  (we[g]),
            .wb_adr_in (adr[g]),
            .wb_dat_in (wdat[g]),
            .wb_sel_in (sel[g]),
            .wb_dat_out(rdat[g]),
            .wb_ack_out(ack[g]),
            .wb_err_out(err[g])
        );
    end

    task automatic bus_idle(input int d);
        cyc[d]  = 1'b0;
        stb[d]  = 1'b0;
        we[d]   = 1'b0;
        adr[d]  = 32'h0;
        wdat[d] = 32'h0;
        sel[d]  = 4'h0;
    endtask

    // One transfer starting at a falling edge; lat counts falling edges after the
    // accepting edge until ack/err is seen, clean reports the cycle after is quiet.
    task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [31:0] dv,
                        input logic [3:0] s, output logic [31:0] rd, output int lat,
                        output logic got_ack, output logic got_err, output logic clean);
        rd = 32'h0; lat = -1; got_ack = 1'b0; got_err = 1'b0; clean = 1'b0;
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; wdat[d] = dv; sel[d] = s;
        @(posedge clk);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (ack[d] || err[d]) begin
                got_ack = ack[d];
                got_err = err[d];
                rd      = rdat[d];
                lat     = c;
                break;
            end
        end
        bus_idle(d);
        @(negedge clk);
        clean = !ack[d] && !err[d] && (rdat[d] == 32'h0);
    endtask

    task automatic test_reset;
        #11;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({ack[d], err[d], rdat[d]} !== 34'h0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d got ack=%0b err=%0b dat=%h expected 0 0 0",
                         d, ack[d], err[d], rdat[d]);
            end
        end
    endtask

    task automatic test_write_read;
        logic [31:0] rd; int lat; logic a, e, cl;
        xfer(0, 1'b1, BASE + 32'd8, 32'hDEAD_BEEF, 4'hF, rd, lat, a, e, cl);
        checks++;
        if ({a, e, cl, rd} !== {3'b101, 32'h0} || lat !== 1) begin
            errors++;
            $display("FAIL ws0_write got ack=%0b err=%0b clean=%0b dat=%h lat=%0d expected 1 0 1 0 lat=1",
                     a, e, cl, rd, lat);
        end
        xfer(0, 1'b0, BASE + 32'd8, 32'h0, 4'hF, rd, lat, a, e, cl);
        checks++;
        if ({a, e, cl, rd} !== {3'b101, 32'hDEAD_BEEF} || lat !== 1) begin
            errors++;
            $display("FAIL ws0_read got ack=%0b err=%0b clean=%0b dat=%h lat=%0d expected 1 0 1 deadbeef lat=1",
                     a, e, cl, rd, lat);
        end
    endtask

    task automatic test_byte_lanes;
        logic [31:0] rd; int lat; logic a, e, cl;
        xfer(0, 1'b1, BASE + 32'd12, 32'h1122_3344, 4'hF, rd, lat, a, e, cl);
        xfer(0, 1'b1, BASE + 32'd12, 32'hAABB_CCDD, 4'b0101, rd, lat, a, e, cl);
        checks++;
        if ({a, e} !== 2'b10) begin
            errors++;
            $display("FAIL lane_write got ack=%0b err=%0b expected 1 0", a, e);
        end
        xfer(0, 1'b0, BASE + 32'd12, 32'h0, 4'b0000, rd, lat, a, e, cl);
        checks++;
        if ({a, e, rd} !== {2'b10, 32'h11BB_33DD}) begin
            errors++;
            $display("FAIL lane_read got ack=%0b err=%0b dat=%h expected 1 0 11bb33dd", a, e, rd);
        end
    endtask

    task automatic test_errors;
        logic [31:0] rd; int lat; logic a, e, cl; logic seen;
        xfer(0, 1'b0, BASE + DEPTH * 4, 32'h0, 4'hF, rd, lat, a, e, cl);
        checks++;
        if ({a, e, cl, rd} !== {3'b011, 32'h0} || lat !== 1) begin
            errors++;
            $display("FAIL err_window got ack=%0b err=%0b clean=%0b dat=%h lat=%0d expected 0 1 1 0 lat=1",
                     a, e, cl, rd, lat);
        end
        xfer(0, 1'b1, BASE, 32'h5555_AAAA, 4'hF, rd, lat, a, e, cl);
        xfer(0, 1'b1, BASE + 32'd2, 32'hFFFF_FFFF, 4'hF, rd, lat, a, e, cl);
        checks++;
        if ({a, e, rd} !== {2'b01, 32'h0}) begin
            errors++;
            $display("FAIL err_misaligned got ack=%0b err=%0b dat=%h expected 0 1 0", a, e, rd);
        end
        xfer(0, 1'b0, BASE, 32'h0, 4'hF, rd, lat, a, e, cl);
        checks++;
        if ({a, e, rd} !== {2'b10, 32'h5555_AAAA}) begin
            errors++;
            $display("FAIL misaligned_readback got ack=%0b err=%0b dat=%h expected 1 0 5555aaaa", a, e, rd);
        end
        xfer(0, 1'b0, BASE - 32'd4, 32'h0, 4'hF, rd, lat, a, e, cl);
        checks++;
        if ({a, e} !== 2'b01) begin
            errors++;
            $display("FAIL err_wrap got ack=%0b err=%0b expected 0 1", a, e);
        end
        seen = 1'b0;
        stb[0] = 1'b1; adr[0] = BASE + 32'd8;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (ack[0] || err[0]) seen = 1'b1;
        end
        bus_idle(0);
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL stb_without_cyc got response=%0b expected 0", seen);
        end
    endtask

    task automatic test_wait_states;
        logic [31:0] rd; int lat; logic a, e, cl;
        xfer(1, 1'b1, BASE + 32'd8, 32'h0BAD_F00D, 4'hF, rd, lat, a, e, cl);
        checks++;
        if ({a, e, cl} !== 3'b101 || lat !== 4) begin
            errors++;
            $display("FAIL ws3_write got ack=%0b err=%0b clean=%0b lat=%0d expected 1 0 1 lat=4",
                     a, e, cl, lat);
        end
        xfer(1, 1'b0, BASE + 32'd8, 32'h0, 4'hF, rd, lat, a, e, cl);
        checks++;
        if ({a, e, rd} !== {2'b10, 32'h0BAD_F00D} || lat !== 4) begin
            errors++;
            $display("FAIL ws3_read got ack=%0b err=%0b dat=%h lat=%0d expected 1 0 0badf00d lat=4",
                     a, e, rd, lat);
        end
    endtask

    task automatic test_back_to_back;
        int n; int pos [3]; int bad_dat;
        n = 0; bad_dat = 0;
        pos[0] = -1; pos[1] = -1; pos[2] = -1;
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; adr[1] = BASE + 32'd8; sel[1] = 4'hF;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (ack[1]) begin
                if (n < 3) pos[n] = c;
                n++;
                if (rdat[1] !== 32'h0BAD_F00D) bad_dat++;
            end
        end
        bus_idle(1);
        repeat (4) @(negedge clk);
        checks++;
        if (n !== 3 || pos[0] !== 4 || pos[1] !== 9 || pos[2] !== 14 || bad_dat !== 0) begin
            errors++;
            $display("FAIL back_to_back got acks=%0d at %0d,%0d,%0d bad_dat=%0d expected 3 at 4,9,14 bad_dat=0",
                     n, pos[0], pos[1], pos[2], bad_dat);
        end
    endtask

    task automatic test_abort;
        logic [31:0] rd; int lat; logic a, e, cl; logic seen;
        xfer(2, 1'b1, BASE + 32'd16, 32'h1234_5678, 4'hF, rd, lat, a, e, cl);
        checks++;
        if ({a, e} !== 2'b10 || lat !== 3) begin
            errors++;
            $display("FAIL ws2_write got ack=%0b err=%0b lat=%0d expected 1 0 lat=3", a, e, lat);
        end
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; adr[2] = BASE + 32'd16;
        wdat[2] = 32'h0000_00FF; sel[2] = 4'hF;
        @(posedge clk);
        @(negedge clk);
        bus_idle(2);
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ack[2] || err[2]) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL abort_response got response=%0b expected 0", seen);
        end
        xfer(2, 1'b0, BASE + 32'd16, 32'h0, 4'hF, rd, lat, a, e, cl);
        checks++;
        if ({a, e, rd} !== {2'b10, 32'h1234_5678}) begin
            errors++;
            $display("FAIL abort_readback got ack=%0b err=%0b dat=%h expected 1 0 12345678", a, e, rd);
        end
    endtask

    task automatic test_async_reset;
        logic [31:0] rd; int lat; logic a, e, cl; logic seen;
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; adr[2] = BASE + 32'd16;
        wdat[2] = 32'hCAFE_F00D; sel[2] = 4'hF;
        @(posedge clk);
        #2 rst_n = 1'b0;
        stb[2] = 1'b0;
        #1;
        checks++;
        if ({ack[2], err[2], rdat[2]} !== 34'h0) begin
            errors++;
            $display("FAIL reset_mid_wait got ack=%0b err=%0b dat=%h expected 0 0 0", ack[2], err[2], rdat[2]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (ack[2] || err[2]) seen = 1'b1;
        end
        bus_idle(2);
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_state_idle got response=%0b expected 0", seen);
        end
        xfer(2, 1'b0, BASE + 32'd16, 32'h0, 4'hF, rd, lat, a, e, cl);
        checks++;
        if ({a, e, rd} !== {2'b10, 32'h1234_5678} || lat !== 3) begin
            errors++;
            $display("FAIL reset_fresh_read got ack=%0b err=%0b dat=%h lat=%0d expected 1 0 12345678 lat=3",
                     a, e, rd, lat);
        end
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = BASE + 32'd8; sel[0] = 4'hF;
        @(posedge clk);
        #1;
        checks++;
        if ({ack[0], rdat[0]} !== {1'b1, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL pre_reset_ack got ack=%0b dat=%h expected 1 deadbeef", ack[0], rdat[0]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ack[0], err[0], rdat[0]} !== 34'h0) begin
            errors++;
            $display("FAIL reset_clears_ack got ack=%0b err=%0b dat=%h expected 0 0 0", ack[0], err[0], rdat[0]);
        end
        bus_idle(0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        xfer(0, 1'b0, BASE + 32'd8, 32'h0, 4'hF, rd, lat, a, e, cl);
        checks++;
        if ({a, e, rd} !== {2'b10, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL ram_kept_over_reset got ack=%0b err=%0b dat=%h expected 1 0 deadbeef", a, e, rd);
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) bus_idle(d);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        test_reset;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        $display("[TB] reset released");
        test_write_read;
        test_byte_lanes;
        test_errors;
        test_wait_states;
        test_back_to_back;
        test_abort;
        test_async_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
